// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared DDR2 user port: holds ownership across
// multi-command sequences, routes read data and flags protocol violations.
module mem_port_arbiter #(
    parameter int OUTS_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        b_req,
    output logic        a_gnt,
    output logic        b_gnt,
    input  logic [29:0] a_addr,
    input  logic [29:0] b_addr,
    input  logic        a_read_write,
    input  logic        b_read_write,
    input  logic        a_mem_op,
    input  logic        b_mem_op,
    input  logic [31:0] a_data_out,
    input  logic [31:0] b_data_out,
    output logic        a_ready,
    output logic        b_ready,
    output logic        a_data_ready,
    output logic        b_data_ready,
    output logic [31:0] a_data_in,
    output logic [31:0] b_data_in,
    input  logic        pX_ready,
    input  logic [31:0] pX_data_in,
    input  logic        pX_data_ready,
    output logic [29:0] pX_addr,
    output logic        pX_read_write,
    output logic        pX_mem_op,
    output logic [31:0] pX_data_out,
    output logic        busy,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, TURN} state_t;

    state_t              state_q, state_d;
    logic                last_b_q, last_b_d;
    logic [OUTS_W-1:0]   outs_q, outs_d;
    logic                op_prev_q, op_prev_d;
    logic                err_q, err_d;

    logic                fwd_op;
    logic                rd_start;
    logic                rel_ok;

    assign a_gnt = (state_q == GRANT_A);
    assign b_gnt = (state_q == GRANT_B);
    assign busy  = (state_q != IDLE);
    assign proto_err = err_q;

    assign a_ready      = a_gnt & pX_ready;
    assign b_ready      = b_gnt & pX_ready;
    assign a_data_ready = a_gnt & pX_data_ready;
    assign b_data_ready = b_gnt & pX_data_ready;
    assign a_data_in    = pX_data_in;
    assign b_data_in    = pX_data_in;

    // Port mux; an unowned port is parked as an idle read at address 0.
    always_comb begin
        fwd_op        = 1'b0;
        pX_addr       = '0;
        pX_read_write = 1'b1;
        pX_data_out   = '0;
        if (a_gnt) begin
            fwd_op        = a_mem_op;
            pX_addr       = a_addr;
            pX_read_write = a_read_write;
            pX_data_out   = a_data_out;
        end else if (b_gnt) begin
            fwd_op        = b_mem_op;
            pX_addr       = b_addr;
            pX_read_write = b_read_write;
            pX_data_out   = b_data_out;
        end
    end

    assign pX_mem_op = fwd_op & ~reset;
    assign rd_start  = fwd_op & ~op_prev_q & pX_read_write;
    assign rel_ok    = (outs_q == '0) & ~fwd_op & pX_ready;

    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        outs_d    = outs_q;
        op_prev_d = fwd_op;
        err_d     = err_q;

        if ((a_mem_op & ~a_gnt) | (b_mem_op & ~b_gnt))
            err_d = 1'b1;

        // Simultaneous start and return leave the count unchanged.
        if (rd_start & ~pX_data_ready) begin
            if (outs_q == '1) err_d = 1'b1;
            else              outs_d = outs_q + 1'b1;
        end else if (pX_data_ready & ~rd_start) begin
            if (outs_q == '0) err_d = 1'b1;
            else              outs_d = outs_q - 1'b1;
        end else if (pX_data_ready & rd_start & (outs_q == '0)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (a_req & (~b_req | last_b_q)) state_d = GRANT_A;
                else if (b_req)                  state_d = GRANT_B;
            end
            GRANT_A: begin
                if (~a_req & rel_ok) begin
                    state_d  = TURN;
                    last_b_d = 1'b0;
                end
            end
            GRANT_B: begin
                if (~b_req & rel_ok) begin
                    state_d  = TURN;
                    last_b_d = 1'b1;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            outs_q    <= '0;
            op_prev_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            outs_q    <= outs_d;
            op_prev_q <= op_prev_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with immediate-assertion checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req, a_gnt, b_gnt;
    logic [29:0] a_addr, b_addr, pX_addr;
    logic        a_read_write, b_read_write, a_mem_op, b_mem_op;
    logic [31:0] a_data_out, b_data_out, a_data_in, b_data_in;
    logic        a_ready, b_ready, a_data_ready, b_data_ready;
    logic        pX_ready, pX_data_ready, pX_read_write, pX_mem_op;
    logic [31:0] pX_data_in, pX_data_out;
    logic        busy, proto_err;

    int n_cmp = 0;
    int n_err = 0;
    int rd_starts = 0;
    int wr_starts = 0;
    int a_dr_cnt = 0;
    logic [31:0] a_dr_val = '0;
    logic op_d = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.OUTS_W(3)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .b_req(b_req), .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_addr(a_addr), .b_addr(b_addr),
        .a_read_write(a_read_write), .b_read_write(b_read_write),
        .a_mem_op(a_mem_op), .b_mem_op(b_mem_op),
        .a_data_out(a_data_out), .b_data_out(b_data_out),
        .a_ready(a_ready), .b_ready(b_ready),
        .a_data_ready(a_data_ready), .b_data_ready(b_data_ready),
        .a_data_in(a_data_in), .b_data_in(b_data_in),
        .pX_ready(pX_ready), .pX_data_in(pX_data_in),
        .pX_data_ready(pX_data_ready), .pX_addr(pX_addr),
        .pX_read_write(pX_read_write), .pX_mem_op(pX_mem_op),
        .pX_data_out(pX_data_out), .busy(busy), .proto_err(proto_err)
    );

    always @(posedge clk) begin
        if (pX_mem_op && !op_d) begin
            if (pX_read_write) rd_starts++;
            else               wr_starts++;
        end
        op_d <= pX_mem_op;
        if (a_data_ready) begin
            a_dr_cnt++;
            a_dr_val <= a_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 0; b_req = 0; a_mem_op = 0; b_mem_op = 0;
        a_read_write = 1; b_read_write = 1;
        a_addr = '0; b_addr = 30'h2222; a_data_out = '0; b_data_out = '0;
        pX_ready = 1; pX_data_ready = 0; pX_data_in = '0;
        tick(); tick();

        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", proto_err, 0);
        chk("rst_memop", pX_mem_op, 0);
        chk("rst_rw", pX_read_write, 1);
        chk("rst_addr", pX_addr, 0);
        chk("rst_dout", pX_data_out, 0);
        chk("rst_a_rdy", a_ready, 0);
        chk("rst_b_rdy", b_ready, 0);

        // Single A read-modify-write
        reset = 0;
        a_req = 1; a_addr = 30'h1234; a_read_write = 1;
        tick();
        chk("rmw_a_gnt", a_gnt, 1);
        chk("rmw_b_gnt", b_gnt, 0);
        chk("rmw_busy", busy, 1);
        a_mem_op = 1;
        #1;
        chk("rmw_memop", pX_mem_op, 1);
        chk("rmw_addr", pX_addr, 32'h1234);
        chk("rmw_a_rdy", a_ready, 1);
        tick(); tick(); tick();
        a_mem_op = 0;
        tick(); tick(); tick();
        pX_data_in = 32'd5; pX_data_ready = 1;
        #1;
        chk("rmw_a_dr", a_data_ready, 1);
        chk("rmw_a_din", a_data_in, 5);
        chk("rmw_b_dr", b_data_ready, 0);
        tick();
        pX_data_ready = 0;
        a_read_write = 0; a_data_out = 32'd6; a_mem_op = 1;
        #1;
        chk("rmw_wdata", pX_data_out, 6);
        chk("rmw_wr", pX_read_write, 0);
        tick();
        a_mem_op = 0; a_req = 0;
        tick();
        chk("rmw_rel_gnt", a_gnt, 0);
        chk("rmw_turn_busy", busy, 1);
        tick();
        chk("rmw_idle_busy", busy, 0);
        chk("rmw_rd_starts", rd_starts, 1);
        chk("rmw_wr_starts", wr_starts, 1);
        chk("rmw_dr_cnt", a_dr_cnt, 1);
        chk("rmw_dr_val", a_dr_val, 5);
        chk("rmw_err", proto_err, 0);

        // Simultaneous requests from reset
        reset = 1; a_read_write = 1;
        tick();
        reset = 0; a_req = 1; b_req = 1;
        tick();
        chk("sim_a_first", a_gnt, 1);
        chk("sim_b_wait", b_gnt, 0);
        tick();
        a_req = 0;
        tick();
        chk("sim_turn_a", a_gnt, 0);
        chk("sim_turn_b", b_gnt, 0);
        chk("sim_turn_op", pX_mem_op, 0);
        tick();
        chk("sim_idle_b", b_gnt, 0);
        chk("sim_idle_busy", busy, 0);
        tick();
        chk("sim_b_gnt", b_gnt, 1);

        // Ungranted strobe during GRANT_A
        b_req = 0;
        tick(); tick();
        a_req = 1;
        tick();
        chk("ung_a_gnt", a_gnt, 1);
        b_mem_op = 1;
        #1;
        chk("ung_memop", pX_mem_op, 0);
        tick();
        b_mem_op = 0;
        chk("ung_err", proto_err, 1);
        tick(); tick();
        chk("ung_sticky", proto_err, 1);
        chk("ung_rd_starts", rd_starts, 1);

        // Early req drop with a read outstanding
        reset = 1; a_req = 0;
        tick();
        chk("edr_rst_err", proto_err, 0);
        reset = 0; a_req = 1;
        tick();
        a_read_write = 1; a_mem_op = 1;
        tick();
        a_mem_op = 0; a_req = 0;
        tick(); tick();
        chk("edr_hold", a_gnt, 1);
        pX_data_ready = 1; pX_data_in = 32'h77;
        tick();
        pX_data_ready = 0;
        chk("edr_hold2", a_gnt, 1);
        tick();
        chk("edr_rel", a_gnt, 0);
        chk("edr_err", proto_err, 0);
        tick(); tick();

        // B back-to-back reads with coincident start and return
        b_req = 1; b_read_write = 1;
        tick();
        chk("b2b_gnt", b_gnt, 1);
        b_mem_op = 1;
        tick();
        b_mem_op = 0;
        tick();
        b_mem_op = 1; pX_data_ready = 1;
        #1;
        chk("b2b_b_dr", b_data_ready, 1);
        chk("b2b_a_dr", a_data_ready, 0);
        tick();
        b_mem_op = 0; pX_data_ready = 0; b_req = 0;
        tick(); tick();
        chk("b2b_hold", b_gnt, 1);
        pX_data_ready = 1;
        tick();
        pX_data_ready = 0;
        chk("b2b_hold2", b_gnt, 1);
        tick();
        chk("b2b_rel", b_gnt, 0);
        chk("b2b_err", proto_err, 0);
        tick(); tick();

        // Reset in GRANT_B with two reads outstanding
        b_req = 1;
        tick();
        chk("rmg_gnt", b_gnt, 1);
        b_mem_op = 1;
        tick();
        b_mem_op = 0;
        tick();
        b_mem_op = 1;
        tick();
        reset = 1;
        #1;
        chk("rmg_op_comb", pX_mem_op, 0);
        tick();
        reset = 0; b_mem_op = 0; b_req = 0;
        chk("rmg_gnt0", b_gnt, 0);
        chk("rmg_op0", pX_mem_op, 0);
        chk("rmg_busy", busy, 0);
        chk("rmg_err0", proto_err, 0);
        pX_data_ready = 1;
        tick();
        pX_data_ready = 0;
        chk("rmg_late_err", proto_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
